// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath widths and the fetch-to-decode entry.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] IMEM_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Small synchronous buffer of fetched {pc, instr} entries between memory and decode.
// Flush wins over a same-cycle push so stale words never survive a redirect.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic   [PW-1:0] wr_ptr;
    logic   [PW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // The fetch credit scheme must make this unreachable.
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited word requests to imem and
// drops responses that were already in flight when a redirect arrived.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] target_pc;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            acc;
    logic            live_rsp;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign pop       = if_valid & if_ready;
    assign acc       = imem_req_valid & imem_req_ready;
    assign live_rsp  = imem_rsp_valid & (discard == '0);
    assign target_pc = redirect_pc & IMEM_ALIGN_MASK;

    // Buffered plus in-flight words may never exceed the buffer size; a same-cycle
    // pop frees a slot early so a 1-cycle memory streams without bubbles.
    assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
    assign imem_req_valid = rst_n & ~redirect_valid & (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = req_pc;

    always_comb begin
        outstanding_next = outstanding;
        if (acc && !imem_rsp_valid) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!acc && imem_rsp_valid) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = rsp_pc;
        push_entry.instr = imem_rsp_data;
    end

    // On redirect every word still in flight after this cycle is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                req_pc  <= target_pc;
                rsp_pc  <= target_pc;
                discard <= outstanding_next;
            end else begin
                if (acc) begin
                    req_pc <= req_pc + 32'd4;
                end
                if (live_rsp) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (imem_rsp_valid && discard != '0) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    rv32i_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (live_rsp),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign if_valid = ~fifo_empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: behavioural in-order imem with selectable latency
// and a decode-side scoreboard that checks every consumed {pc, instr}.
module tb_rv32i_fetch;
    import rv32i_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          cyc = 0;
    int          acc_total = 0;
    int          pop_total = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] next_req = RESET_PC;
    mem_req_t    mem_q[$];

    rv32i_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic req_rdy, input logic redir, input logic [31:0] rpc);
        if_ready       = rdy;
        imem_req_ready = req_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(if_valid), 32'd1);
    endtask

    // Memory presents responses at negedge; decode/request activity is observed just
    // after, while all inputs are stable ahead of the next rising edge.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
            exp_pc         = RESET_PC;
            next_req       = RESET_PC;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            #2;
            if (redirect_valid) begin
                exp_pc   = redirect_pc & 32'hFFFF_FFFC;
                next_req = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (if_valid && if_ready) begin
                    checkOutput("pop_pc", if_pc, exp_pc);
                    checkOutput("pop_instr", if_instr, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    pop_total++;
                end
                if (imem_req_valid && imem_req_ready) begin
                    checkOutput("req_addr", imem_req_addr, next_req);
                    next_req = next_req + 32'd4;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: imem_req_addr, ready: cyc + lat});
                acc_total++;
            end
        end
        cyc++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc0;
        int pop0;
        int n;

        // Reset state
        tick();
        tick();
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);

        // Streaming from RESET_PC with 1-cycle memory
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("s1_req_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("s1_req_addr", imem_req_addr, RESET_PC + 32'(4 * k));
            checkOutput("s1_if_valid", 32'(if_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                checkOutput("s1_if_pc", if_pc, RESET_PC + 32'(4 * (k - 2)));
            end
            tick();
        end

        // Decode stall: the buffer fills and requests stop
        acc0 = acc_total;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (10) tick();
        checkOutput("s2_stall_acc", 32'(acc_total - acc0), 32'd0);
        checkOutput("s2_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("s2_if_valid", 32'(if_valid), 32'd1);
        checkOutput("s2_head_pc", if_pc, exp_pc);
        pop0 = pop_total;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (8) tick();
        checkOutput("s2_pops", 32'(pop_total - pop0), 32'd8);

        // Memory back-pressure: request and address held
        acc0 = acc_total;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("s5_req_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("s5_req_addr", imem_req_addr, next_req);
            tick();
        end
        checkOutput("s5_stall_acc", 32'(acc_total - acc0), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("s5_release_acc", 32'(acc_total - acc0), 32'd1);

        // 2-cycle memory, redirect with two requests outstanding
        lat = 2;
        n = 0;
        while (mem_q.size() != 2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("s3_two_inflight", 32'(mem_q.size()), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        checkOutput("s3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        wait_valid("s3");
        checkOutput("s3_if_pc", if_pc, 32'h0000_0100);
        checkOutput("s3_if_instr", if_instr, mem_word(32'h0000_0100));
        repeat (4) tick();

        // Back-to-back redirects
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_4002);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        wait_valid("b2b");
        checkOutput("b2b_if_pc", if_pc, 32'h0000_4000);

        // Redirect during a live response with 1-cycle memory
        lat = 1;
        repeat (10) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000);
        checkOutput("s4_redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("s4_n1_if_valid", 32'(if_valid), 32'd0);
        checkOutput("s4_n1_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("s4_n1_req_addr", imem_req_addr, 32'h0000_2000);
        tick();
        checkOutput("s4_n2_if_valid", 32'(if_valid), 32'd0);
        tick();
        checkOutput("s4_n3_if_valid", 32'(if_valid), 32'd1);
        checkOutput("s4_n3_if_pc", if_pc, 32'h0000_2000);
        checkOutput("s4_n3_if_instr", if_instr, mem_word(32'h0000_2000));
        repeat (4) tick();

        // Async reset with the buffer full
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (6) tick();
        checkOutput("s6_full_if_valid", 32'(if_valid), 32'd1);
        checkOutput("s6_full_req_valid", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("s6_async_if_valid", 32'(if_valid), 32'd0);
        checkOutput("s6_async_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("s6_async_if_pc", if_pc, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("s6_restart_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("s6_restart_addr", imem_req_addr, RESET_PC);
        wait_valid("s6");
        checkOutput("s6_restart_if_pc", if_pc, RESET_PC);
        checkOutput("s6_restart_if_instr", if_instr, mem_word(RESET_PC));
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
